split_line_fetch_sched: RTL and testbench

//  Per-line read scheduler feeding the split-screen mixer's two line FIFOs over one shared frame-buffer read port.
//  On each line request it fetches 512 px of the original image (left FIFO) and 512 px of the processed image (right FIFO).

---
 rtl/split_line_fetch_sched_if.sv | 22 ++
 rtl/split_line_fetch_sched.sv | 169 ++++++++++++++++
 tb/tb_split_line_fetch_sched.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_line_fetch_sched_if.sv
// Frame-buffer read-request bus between the line fetch scheduler and the DDR read master.
// Only one burst is outstanding at a time: rd_req is held until rd_ack, and rd_done closes the burst.
interface split_line_fetch_sched_if #(
    parameter int ADDR_W = 24
);
    logic              rd_req;
    logic              rd_ack;
    logic              rd_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_sel;

    modport master (
        output rd_req, rd_addr, rd_len, rd_sel,
        input  rd_ack, rd_done
    );

    modport slave (
        input  rd_req, rd_addr, rd_len, rd_sel,
        output rd_ack, rd_done
    );
endinterface

// File: rtl/split_line_fetch_sched.sv
// Per-line read scheduler for the split-screen mixer: fetches one half-line from each image
// buffer in fixed-size bursts over a single read port, arbitrating the two sides round-robin.
module split_line_fetch_sched #(
    parameter int              HALF_W     = 512,
    parameter int              V_ACTIVE   = 768,
    parameter int              BURST_LEN  = 64,
    parameter int              ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] LEFT_BASE  = 24'h000000,
    parameter logic [ADDR_W-1:0] RIGHT_BASE = 24'h0C0000
) (
    input  logic                           pixel_clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           line_req,
    input  logic                           left_room,
    input  logic                           right_room,
    split_line_fetch_sched_if.master       rd,
    output logic                           line_busy,
    output logic                           frame_done,
    output logic                           line_overrun
);

    localparam int NB     = HALF_W / BURST_LEN;
    localparam int CNT_W  = $clog2(NB + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT} state_t;

    state_t              state, state_nxt;
    logic [LINE_W-1:0]   line, line_nxt;
    logic [CNT_W-1:0]    l_cnt, l_cnt_nxt, r_cnt, r_cnt_nxt;
    logic                last_sel, last_sel_nxt;
    logic                abort, abort_nxt;
    logic                req_q, req_nxt;
    logic                sel_q, sel_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                busy_nxt, frame_done_nxt, overrun_nxt;
    logic                l_elig, r_elig, pick, can_start;
    logic [ADDR_W-1:0]   line_off, l_addr, r_addr;

    assign line_off = ADDR_W'(line) * ADDR_W'(HALF_W);
    assign l_addr   = LEFT_BASE  + line_off + ADDR_W'(l_cnt) * ADDR_W'(BURST_LEN);
    assign r_addr   = RIGHT_BASE + line_off + ADDR_W'(r_cnt) * ADDR_W'(BURST_LEN);
    assign l_elig   = (l_cnt < CNT_W'(NB)) && left_room;
    assign r_elig   = (r_cnt < CNT_W'(NB)) && right_room;

    assign rd.rd_req  = req_q;
    assign rd.rd_addr = addr_q;
    assign rd.rd_sel  = sel_q;
    assign rd.rd_len  = 8'(BURST_LEN);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            line         <= '0;
            l_cnt        <= '0;
            r_cnt        <= '0;
            last_sel     <= 1'b1;
            abort        <= 1'b0;
            req_q        <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            line_busy    <= 1'b0;
            frame_done   <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            state        <= state_nxt;
            line         <= line_nxt;
            l_cnt        <= l_cnt_nxt;
            r_cnt        <= r_cnt_nxt;
            last_sel     <= last_sel_nxt;
            abort        <= abort_nxt;
            req_q        <= req_nxt;
            sel_q        <= sel_nxt;
            addr_q       <= addr_nxt;
            line_busy    <= busy_nxt;
            frame_done   <= frame_done_nxt;
            line_overrun <= overrun_nxt;
        end
    end

    // A frame_start seen in WAIT is remembered in abort, because the in-flight burst must drain first.
    always_comb begin
        state_nxt      = state;
        line_nxt       = line;
        l_cnt_nxt      = l_cnt;
        r_cnt_nxt      = r_cnt;
        last_sel_nxt   = last_sel;
        abort_nxt      = abort;
        req_nxt        = req_q;
        sel_nxt        = sel_q;
        addr_nxt       = addr_q;
        busy_nxt       = line_busy;
        frame_done_nxt = 1'b0;
        overrun_nxt    = line_overrun;
        pick           = 1'b0;
        can_start      = 1'b0;

        if (frame_start) begin
            line_nxt    = '0;
            overrun_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
            end
            ARB: begin
                if (frame_start) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else if (l_cnt == CNT_W'(NB) && r_cnt == CNT_W'(NB)) begin
                    state_nxt      = IDLE;
                    busy_nxt       = 1'b0;
                    line_nxt       = line + 1'b1;
                    frame_done_nxt = (line_nxt == LINE_W'(V_ACTIVE));
                end else if (l_elig || r_elig) begin
                    pick      = (l_elig && r_elig) ? !last_sel : r_elig;
                    sel_nxt   = pick;
                    addr_nxt  = pick ? r_addr : l_addr;
                    req_nxt   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rd.rd_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = WAIT;
                    if (frame_start) abort_nxt = 1'b1;
                end else if (frame_start) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            WAIT: begin
                if (frame_start) abort_nxt = 1'b1;
                if (rd.rd_done) begin
                    if (abort || frame_start) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        abort_nxt = 1'b0;
                    end else begin
                        if (sel_q) r_cnt_nxt = r_cnt + 1'b1;
                        else       l_cnt_nxt = l_cnt + 1'b1;
                        last_sel_nxt = sel_q;
                        state_nxt    = ARB;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A line may start if idle, or if frame_start just aborted the line in progress.
        can_start = !line_busy || (frame_start && state_nxt == IDLE);
        if (line_req) begin
            if (!can_start) begin
                overrun_nxt = 1'b1;
            end else if (line_nxt < LINE_W'(V_ACTIVE)) begin
                state_nxt    = ARB;
                busy_nxt     = 1'b1;
                l_cnt_nxt    = '0;
                r_cnt_nxt    = '0;
                last_sel_nxt = 1'b1;
                abort_nxt    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_split_line_fetch_sched.sv
// Self-checking bench for split_line_fetch_sched: a randomized read-master responder records every
// accepted burst, and each line is compared against addresses derived from the line/burst arithmetic.
module tb_split_line_fetch_sched;

    localparam int HALF_W    = 512;
    localparam int V_ACTIVE  = 768;
    localparam int BURST_LEN = 64;
    localparam int ADDR_W    = 24;
    localparam int NB        = HALF_W / BURST_LEN;

    typedef struct {
        logic              sel;
        logic [ADDR_W-1:0] addr;
    } burst_t;

    logic pixel_clk   = 1'b0;
    logic rst_n       = 1'b0;
    logic frame_start = 1'b0;
    logic line_req    = 1'b0;
    logic left_room   = 1'b1;
    logic right_room  = 1'b1;
    logic line_busy, frame_done, line_overrun;

    int tests = 0;
    int fails = 0;
    int model_line = 0;
    int ack_dly = 4;
    int done_dly = 4;
    int resp_phase = 0;
    int unstable_cnt = 0;
    int overlap_cnt = 0;
    int room_err = 0;
    int req_rise_cnt = 0;
    int fdone_cnt = 0;
    burst_t log_q[$];

    split_line_fetch_sched_if #(.ADDR_W(ADDR_W)) rd_bus ();

    split_line_fetch_sched #(
        .HALF_W(HALF_W), .V_ACTIVE(V_ACTIVE), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W),
        .LEFT_BASE(24'h000000), .RIGHT_BASE(24'h0C0000)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .frame_start(frame_start), .line_req(line_req),
        .left_room(left_room), .right_room(right_room), .rd(rd_bus),
        .line_busy(line_busy), .frame_done(frame_done), .line_overrun(line_overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Read master model: acks after ack_dly cycles, signals done done_dly cycles later, logs each burst.
    initial begin : responder
        int cnt;
        logic [ADDR_W-1:0] cap_addr;
        logic cap_sel;
        cnt = 0; cap_addr = '0; cap_sel = 1'b0;
        rd_bus.rd_ack = 1'b0; rd_bus.rd_done = 1'b0;
        forever begin
            @(posedge pixel_clk); #1;
            rd_bus.rd_ack = 1'b0; rd_bus.rd_done = 1'b0;
            if (!rst_n) resp_phase = 0;
            else begin
                case (resp_phase)
                    0: if (rd_bus.rd_req) begin
                        cap_addr = rd_bus.rd_addr; cap_sel = rd_bus.rd_sel;
                        if (ack_dly == 0) begin
                            rd_bus.rd_ack = 1'b1; log_q.push_back('{sel: cap_sel, addr: cap_addr});
                            cnt = done_dly; resp_phase = 2;
                        end else begin
                            cnt = ack_dly - 1; resp_phase = 1;
                        end
                    end
                    1: begin
                        if (rd_bus.rd_req !== 1'b1 || rd_bus.rd_addr !== cap_addr || rd_bus.rd_sel !== cap_sel)
                            unstable_cnt++;
                        if (cnt == 0) begin
                            rd_bus.rd_ack = 1'b1; log_q.push_back('{sel: cap_sel, addr: cap_addr});
                            cnt = done_dly; resp_phase = 2;
                        end else cnt--;
                    end
                    default: begin
                        if (rd_bus.rd_req !== 1'b0) overlap_cnt++;
                        if (cnt == 0) begin
                            rd_bus.rd_done = 1'b1; resp_phase = 0;
                        end else cnt--;
                    end
                endcase
            end
        end
    end

    // Request-edge monitor: a new request must target a side whose FIFO had room when it was issued.
    initial begin : monitor
        logic prev_req, prev_l, prev_r;
        prev_req = 1'b0; prev_l = 1'b0; prev_r = 1'b0;
        forever begin
            @(negedge pixel_clk);
            if (rd_bus.rd_req === 1'b1 && prev_req !== 1'b1) begin
                req_rise_cnt++;
                if ((rd_bus.rd_sel ? prev_r : prev_l) !== 1'b1) room_err++;
            end
            if (frame_done === 1'b1) fdone_cnt++;
            prev_req = rd_bus.rd_req; prev_l = left_room; prev_r = right_room;
        end
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish before limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [ADDR_W-1:0] exp_addr(input bit sel, input int line, input int k);
        longint a;
        a = (sel ? 64'h0C0000 : 64'h0) + longint'(line) * HALF_W + longint'(k) * BURST_LEN;
        return a[ADDR_W-1:0];
    endfunction

    // mode 0: strict L,R alternation; mode 1: all left then all right; mode 2: per-side order only.
    function automatic int line_errors(input int line, input int mode);
        int li = 0, ri = 0, errs = 0;
        foreach (log_q[k]) begin
            if (mode == 0 && log_q[k].sel !== ((k % 2) == 1)) errs++;
            if (mode == 1 && log_q[k].sel !== (k >= NB)) errs++;
            if (log_q[k].sel) begin
                if (log_q[k].addr !== exp_addr(1'b1, line, ri)) errs++;
                ri++;
            end else begin
                if (log_q[k].addr !== exp_addr(1'b0, line, li)) errs++;
                li++;
            end
        end
        if (li != NB || ri != NB) errs++;
        return errs;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge pixel_clk); #1; end
    endtask

    task automatic pulse_line_req();
        line_req = 1'b1; tick(); line_req = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input bit rand_room, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (line_busy === 1'b1) begin
            if (rand_room) begin left_room = 1'($urandom_range(0, 1)); right_room = 1'($urandom_range(0, 1)); end
            tick(); n++;
            if (n >= max_cyc) begin timed_out = 1'b1; break; end
        end
        left_room = 1'b1; right_room = 1'b1;
    endtask

    task automatic run_line(input int max_cyc, input bit rand_room, output bit timed_out);
        log_q.delete(); pulse_line_req(); wait_idle(max_cyc, rand_room, timed_out);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        tests++; if (rd_bus.rd_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_req: got %b want 0", rd_bus.rd_req); end
        tests++; if (rd_bus.rd_addr !== 24'h0) begin fails++; $display("[TB] FAIL reset_rd_addr: got %h want 0", rd_bus.rd_addr); end
        tests++; if (rd_bus.rd_sel !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_sel: got %b want 0", rd_bus.rd_sel); end
        tests++; if (rd_bus.rd_len !== 8'd64) begin fails++; $display("[TB] FAIL reset_rd_len: got %0d want 64", rd_bus.rd_len); end
        tests++; if (line_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_line_busy: got %b want 0", line_busy); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
        tests++; if (line_overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b want 0", line_overrun); end
        rst_n = 1'b1; tick(2);
        model_line = 0;
    endtask

    task automatic test_basic_line();
        bit to;
        ack_dly = 4; done_dly = 4; log_q.delete();
        line_req = 1'b1; tick(); line_req = 1'b0;
        tests++; if (rd_bus.rd_req !== 1'b0 || line_busy !== 1'b1) begin fails++; $display("[TB] FAIL latency_n1: got req=%b busy=%b want req=0 busy=1", rd_bus.rd_req, line_busy); end
        tick();
        tests++; if (rd_bus.rd_req !== 1'b1 || rd_bus.rd_addr !== 24'h0 || rd_bus.rd_sel !== 1'b0) begin fails++; $display("[TB] FAIL latency_n2: got req=%b addr=%h sel=%b want 1/000000/0", rd_bus.rd_req, rd_bus.rd_addr, rd_bus.rd_sel); end
        wait_idle(800, 1'b0, to);
        tests++; if (to || line_errors(model_line, 0) != 0) begin fails++; $display("[TB] FAIL basic_line: got %0d errors timeout=%b bursts=%0d want 0 errors 16 bursts", line_errors(model_line, 0), to, log_q.size()); end
        model_line++;
    endtask

    task automatic test_right_blocked();
        bit to;
        int lefts = 0;
        right_room = 1'b0; log_q.delete();
        pulse_line_req(); tick(250);
        foreach (log_q[k]) if (log_q[k].sel === 1'b0) lefts++;
        tests++; if (log_q.size() != NB || lefts != NB) begin fails++; $display("[TB] FAIL right_blocked_lefts: got %0d bursts %0d left want 8/8", log_q.size(), lefts); end
        tests++; if (rd_bus.rd_req !== 1'b0 || line_busy !== 1'b1) begin fails++; $display("[TB] FAIL right_blocked_arb: got req=%b busy=%b want req=0 busy=1", rd_bus.rd_req, line_busy); end
        right_room = 1'b1;
        wait_idle(800, 1'b0, to);
        tests++; if (to || line_errors(model_line, 1) != 0) begin fails++; $display("[TB] FAIL right_blocked_line: got %0d errors timeout=%b want 0", line_errors(model_line, 1), to); end
        tests++; if (room_err != 0) begin fails++; $display("[TB] FAIL room_respected: got %0d bad requests want 0", room_err); end
        model_line++;
    endtask

    task automatic test_ack_delay();
        bit to;
        int u0 = unstable_cnt, o0 = overlap_cnt;
        ack_dly = 10; done_dly = 2;
        run_line(1200, 1'b0, to);
        tests++; if (unstable_cnt != u0) begin fails++; $display("[TB] FAIL ack_delay_stable: got %0d unstable cycles want 0", unstable_cnt - u0); end
        tests++; if (overlap_cnt != o0) begin fails++; $display("[TB] FAIL ack_delay_single: got %0d overlapping requests want 0", overlap_cnt - o0); end
        tests++; if (to || line_errors(model_line, 0) != 0) begin fails++; $display("[TB] FAIL ack_delay_line: got %0d errors want 0", line_errors(model_line, 0)); end
        model_line++; ack_dly = 4; done_dly = 4;
    endtask

    task automatic test_overrun();
        bit to;
        log_q.delete(); pulse_line_req(); tick(30);
        tests++; if (line_overrun !== 1'b0) begin fails++; $display("[TB] FAIL overrun_pre: got %b want 0", line_overrun); end
        pulse_line_req();
        tests++; if (line_overrun !== 1'b1) begin fails++; $display("[TB] FAIL overrun_set: got %b want 1", line_overrun); end
        wait_idle(800, 1'b0, to);
        tests++; if (to || log_q.size() != 2 * NB || line_errors(model_line, 0) != 0) begin fails++; $display("[TB] FAIL overrun_line: got %0d bursts %0d errors want 16 bursts 0 errors", log_q.size(), line_errors(model_line, 0)); end
        model_line++; tick(3);
        tests++; if (line_overrun !== 1'b1) begin fails++; $display("[TB] FAIL overrun_sticky: got %b want 1", line_overrun); end
        pulse_frame_start(); model_line = 0;
        tests++; if (line_overrun !== 1'b0) begin fails++; $display("[TB] FAIL overrun_clear: got %b want 0", line_overrun); end
    endtask

    task automatic test_random();
        bit to, rr;
        int u0 = unstable_cnt, o0 = overlap_cnt, e;
        for (int i = 0; i < 6; i++) begin
            ack_dly = $urandom_range(0, 6); done_dly = $urandom_range(0, 6); rr = (i % 2) == 1;
            run_line(2000, rr, to);
            e = line_errors(model_line, rr ? 2 : 0);
            tests++; if (to || e != 0) begin fails++; $display("[TB] FAIL random_line%0d: got %0d errors timeout=%b want 0", i, e, to); end
            model_line++;
        end
        tests++; if (room_err != 0 || overlap_cnt != o0 || unstable_cnt != u0) begin fails++; $display("[TB] FAIL random_protocol: got room=%0d overlap=%0d unstable=%0d want 0/0/0", room_err, overlap_cnt - o0, unstable_cnt - u0); end
    endtask

    task automatic test_frame_start_wait();
        bit to;
        int n, bad = 0, rise0;
        ack_dly = 2; done_dly = 8;
        pulse_frame_start(); model_line = 0;
        for (int l = 0; l < 5; l++) begin
            run_line(1000, 1'b0, to);
            if (to || line_errors(model_line, 0) != 0) bad++;
            model_line++;
        end
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL fs_lines0to4: got %0d bad lines want 0", bad); end
        log_q.delete(); pulse_line_req();
        n = 0;
        while (resp_phase != 2 && n < 60) begin tick(); n++; end
        tests++; if (n >= 60) begin fails++; $display("[TB] FAIL fs_reach_wait: got timeout want burst accepted"); end
        tick(); rise0 = req_rise_cnt;
        pulse_frame_start(); model_line = 0;
        n = 0;
        while (line_busy === 1'b1 && n < 60) begin tick(); n++; end
        tests++; if (n >= 60 || resp_phase != 0) begin fails++; $display("[TB] FAIL fs_drain: got busy=%b phase=%0d want busy=0 after rd_done", line_busy, resp_phase); end
        tick(5);
        tests++; if (req_rise_cnt != rise0 || rd_bus.rd_req !== 1'b0) begin fails++; $display("[TB] FAIL fs_no_new_req: got %0d new requests want 0", req_rise_cnt - rise0); end
        run_line(1000, 1'b0, to);
        tests++; if (to || log_q.size() == 0 || log_q[0].addr !== 24'h0 || line_errors(0, 0) != 0) begin fails++; $display("[TB] FAIL fs_line0: got %0d errors first addr=%h want 0 errors addr 000000", line_errors(0, 0), log_q.size() ? log_q[0].addr : 24'hxxxxxx); end
        model_line = 1;
    endtask

    task automatic test_full_frame();
        bit to;
        int bad = 0, f0, f766 = 0, rise0;
        ack_dly = 0; done_dly = 0;
        pulse_frame_start(); model_line = 0;
        f0 = fdone_cnt;
        for (int l = 0; l < V_ACTIVE; l++) begin
            if (l == V_ACTIVE - 1) f766 = fdone_cnt - f0;
            run_line(200, 1'b0, to);
            if (to || line_errors(l, 0) != 0) bad++;
            if (l == V_ACTIVE - 1) begin
                tests++; if (log_q.size() == 0 || log_q[0].addr !== 24'h05FE00) begin fails++; $display("[TB] FAIL last_line_addr: got %h want 05fe00", log_q.size() ? log_q[0].addr : 24'hxxxxxx); end
            end
        end
        tick(2);
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL frame_lines: got %0d bad lines want 0", bad); end
        tests++; if (f766 != 0 || fdone_cnt - f0 != 1) begin fails++; $display("[TB] FAIL frame_done_pulse: got %0d early %0d total want 0 early 1 total", f766, fdone_cnt - f0); end
        rise0 = req_rise_cnt;
        pulse_line_req(); tick(20);
        tests++; if (req_rise_cnt != rise0 || line_busy !== 1'b0 || line_overrun !== 1'b0) begin fails++; $display("[TB] FAIL extra_line_req: got req=%0d busy=%b ovr=%b want 0/0/0", req_rise_cnt - rise0, line_busy, line_overrun); end
        ack_dly = 4; done_dly = 4;
    endtask

    task automatic test_async_reset();
        bit to;
        log_q.delete(); pulse_line_req(); tick(9);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (rd_bus.rd_req !== 1'b0 || line_busy !== 1'b0 || rd_bus.rd_addr !== 24'h0) begin fails++; $display("[TB] FAIL async_reset: got req=%b busy=%b addr=%h want 0/0/000000", rd_bus.rd_req, line_busy, rd_bus.rd_addr); end
        @(posedge pixel_clk); #1;
        rst_n = 1'b1; tick(2); model_line = 0;
        run_line(800, 1'b0, to);
        tests++; if (to || line_errors(0, 0) != 0) begin fails++; $display("[TB] FAIL after_reset_line: got %0d errors want 0", line_errors(0, 0)); end
    endtask

    initial begin : main
        test_reset();
        test_basic_line();
        test_right_blocked();
        test_ack_delay();
        test_overrun();
        test_random();
        test_frame_start_wait();
        test_full_frame();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
